flip_flop_checker: RTL
======================

# flip_flop_checker

Synthesizable response checker for the JK, SR, D and T flip-flop bank. It watches the same stimulus and clock applied to the bank and predicts each flip-flop's output with its own reference model. Every cycle it compares the bank's outputs against the prediction, counts mismatches and latches the first failure. It sits beside the flip-flop bank in the bench and on silicon-test builds, and turns stimulus-only runs into self-checking runs.

## Interface
Parameters:
- CNT_W, 16, width of the error counter (saturating)
- CYC_W, 32, width of the cycle counter and the first-fail timestamp (saturating)

Ports:
- clk  in  1  single clock, shared with the flip-flop bank; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset of the checker
- en  in  1  checking enable; level-sensitive
- dut_rst  in  1  the bank's own active-high reset, observed only
- j, k, s, r, d, t  in  1 each  stimulus applied to the bank
- q_jk, qb_jk, q_sr, qb_sr, q_d, qb_d, q_t, qb_t  in  1 each  bank outputs
- err  out  1  one-cycle pulse on any mismatch
- err_mask  out  4  mismatching flip-flops in the current cycle, bit order {t, d, sr, jk}
- fail  out  1  sticky; set on the first mismatch
- err_cnt  out  CNT_W  total mismatch cycles
- cyc_cnt  out  CYC_W  cycles spent in CHECK
- first_fail_cyc  out  CYC_W  value of cyc_cnt at the first mismatch
- busy  out  1  high in SYNC or CHECK

## Operation
- States: IDLE, SYNC, CHECK.
  - IDLE -> SYNC when en=1.
  - SYNC -> CHECK after exactly one cycle.
  - Any state -> IDLE when en=0.
- SYNC loads the model state from the observed q_jk, q_sr, q_d, q_t. No comparison is made in SYNC.
- Model next-state rules (pred <= f(pred, inputs sampled this edge)):
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - SR: 00 hold, 01 clear, 10 set, 11 invalid. Invalid marks SR unknown.
  - D: pred <= d.
  - T: toggle when t=1.
- SR unknown: SR comparison is suppressed. The unknown flag is cleared by the first edge with exactly one of s or r high.
- dut_rst=1 at an edge: all four predictions become 0 and SR unknown clears. This overrides the stimulus rules.
- Comparison in CHECK: each edge, the sampled q_x is compared with pred_x. A mismatch sets err_mask bit x.
- Resync on mismatch: any mismatched flip-flop's model is reloaded from the observed q before its next-state rule is applied. One fault therefore counts once, not every following cycle.
- Counters:
  - err_cnt increments by 1 per cycle with a nonzero mask, regardless of how many bits are set.
  - cyc_cnt increments every CHECK cycle.
  - Both saturate at all-ones.
- first_fail_cyc and fail are written only when fail is 0.
- Statistics (fail, err_cnt, cyc_cnt, first_fail_cyc) are cleared only by rst. They persist across en toggles.

## Timing
- Reset values:
  - err=0, err_mask=0, fail=0, busy=0.
  - err_cnt=0, cyc_cnt=0, first_fail_cyc=0.
  - State IDLE; model state 0; SR unknown clear.
- Output alignment: bank outputs sampled at edge n reflect the bank's stimulus at edge n-1. The prediction compared at edge n was computed from stimulus sampled at edge n-1.
- Latency: err, err_mask, err_cnt and fail are registered. They update on the edge that samples the faulty output, visible one cycle after the bank output changes.
- Ordering after en rises: en at edge 0 enters SYNC; edge 1 loads the model; edge 2 is the first compared edge.
- en drop: busy falls on the edge that samples en=0, and err and err_mask read 0 from that edge onward.
- Reset mid-operation: rst low forces all reset values immediately, with no clock needed. Release is taken on the next rising edge.

## Configuration
- FF_CHK_COMPL_EN defined: each qb_x is also checked against ~q_x.
  - A complement failure sets the same err_mask bit as a q mismatch.
  - SR unknown suppresses the SR complement check as well.
- Undefined: all qb_x inputs are ignored, and the complement logic is not built.

## Test plan
- Reset and idle:
  - Hold rst=0 and toggle stimulus: all outputs stay 0.
  - Release rst with en=0: busy=0 and err_cnt=0.
- Clean run against a correct bank:
  - dut_rst=1 for 50 ns, then sweep j,k / s,r through 00, 01, 10 with d=t=1 for 400 ns.
  - Required: fail=0, err_cnt=0, cyc_cnt equals the number of CHECK edges.
- Stuck-at fault:
  - Force q_d=0 while d=1 at CHECK cycle 7.
  - Required: err pulses once, err_mask=4'b0100, err_cnt=1, first_fail_cyc=7, fail=1 sticky.
  - After the force is released and q_d follows again, err_cnt stays 1.
- SR invalid:
  - Apply s=r=1 for 3 cycles, with the bank producing arbitrary q_sr: no SR error.
  - Then s=1, r=0: SR is checked again from the next edge, and a wrong q_sr gives err_mask=4'b0010.
- Counter saturation with CNT_W=2:
  - Inject 5 mismatch cycles: err_cnt sticks at 3.
  - Assert rst=0 mid-run: all outputs are 0 asynchronously.
- With FF_CHK_COMPL_EN:
  - Force qb_t=q_t: err_mask=4'b1000.
  - Without the macro, the same stimulus gives no error.

Source files
------------

// File: rtl/flip_flop_checker.sv
// Response checker for a JK/SR/D/T flip-flop bank. It predicts each output, flags mismatches and keeps error statistics.
// Optional build macro FF_CHK_COMPL_EN: also checks every qb output against ~q.
module flip_flop_checker #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dut_rst,
    input  logic             j,
    input  logic             k,
    input  logic             s,
    input  logic             r,
    input  logic             d,
    input  logic             t,
    input  logic             q_jk,
    input  logic             qb_jk,
    input  logic             q_sr,
    input  logic             qb_sr,
    input  logic             q_d,
    input  logic             qb_d,
    input  logic             q_t,
    input  logic             qb_t,
    output logic             err,
    output logic [3:0]       err_mask,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CYC_W-1:0] cyc_cnt,
    output logic [CYC_W-1:0] first_fail_cyc,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic [1:0]       state;
    logic [3:0]       pred;        // {t, d, sr, jk}
    logic             sr_unk;
    logic [3:0]       obs_q;
    logic [3:0]       cmp_mask;
    logic [3:0]       base;
    logic             base_unk;
    logic [3:0]       pred_nxt;
    logic             unk_nxt;
    logic [CNT_W-1:0] err_cnt_inc;
    logic [CYC_W-1:0] cyc_inc;

    assign obs_q = {q_t, q_d, q_sr, q_jk};
    assign busy  = (state != ST_IDLE);

`ifdef FF_CHK_COMPL_EN
    logic [3:0] obs_qb;
    assign obs_qb = {qb_t, qb_d, qb_sr, qb_jk};
`else
    logic unused_qb;
    assign unused_qb = ^{qb_t, qb_d, qb_sr, qb_jk};
`endif

    always_comb begin
        // NOTE: every variable written here is assigned a default first, so no latch can be inferred.
        cmp_mask = pred ^ obs_q;
`ifdef FF_CHK_COMPL_EN
        cmp_mask = cmp_mask | ~(obs_qb ^ obs_q);
`endif
        if (sr_unk) cmp_mask[1] = 1'b0;

        // A mismatching model is resynchronised to the observed value before stepping forward.
        if (state == ST_SYNC) begin
            base     = obs_q;
            base_unk = 1'b0;
        end else begin
            base     = (pred & ~cmp_mask) | (obs_q & cmp_mask);
            base_unk = sr_unk;
        end

        pred_nxt = base;
        unk_nxt  = base_unk;
        case ({j, k})
            2'b01:   pred_nxt[0] = 1'b0;
            2'b10:   pred_nxt[0] = 1'b1;
            2'b11:   pred_nxt[0] = ~base[0];
            default: ;
        endcase
        case ({s, r})
            2'b01: begin
                pred_nxt[1] = 1'b0;
                unk_nxt     = 1'b0;
            end
            2'b10: begin
                pred_nxt[1] = 1'b1;
                unk_nxt     = 1'b0;
            end
            2'b11:   unk_nxt = 1'b1;
            default: ;
        endcase
        pred_nxt[2] = d;
        pred_nxt[3] = base[3] ^ t;
        if (dut_rst) begin
            pred_nxt = 4'b0;
            unk_nxt  = 1'b0;
        end

        err_cnt_inc = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
        cyc_inc     = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            pred           <= 4'b0;
            sr_unk         <= 1'b0;
            err            <= 1'b0;
            err_mask       <= 4'b0;
            fail           <= 1'b0;
            err_cnt        <= '0;
            cyc_cnt        <= '0;
            first_fail_cyc <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
            err      <= 1'b0;
            err_mask <= 4'b0;
            if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SYNC;
                    ST_SYNC: begin
                        state  <= ST_CHECK;
                        pred   <= pred_nxt;
                        sr_unk <= unk_nxt;
                    end
                    ST_CHECK: begin
                        pred     <= pred_nxt;
                        sr_unk   <= unk_nxt;
                        err      <= |cmp_mask;
                        err_mask <= cmp_mask;
                        cyc_cnt  <= cyc_inc;
                        if (|cmp_mask) begin
                            err_cnt <= err_cnt_inc;
                            if (!fail) begin
                                fail           <= 1'b1;
                                first_fail_cyc <= cyc_inc;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
